// File: rtl/alu_ctrl_decode_stage.sv
// alu_ctrl_decode_stage
//   ID-stage decoder producing the 5-bit ALU control code for the EX-stage ALU.
//   A 32-bit MIPS instruction is decoded into ALU op, operand-B select, extended
//   immediate and register fields, then held in one ID/EX register guarded by a
//   valid/ready handshake with flush.
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               kill held and incoming instruction
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   instr               instruction word
//   out_valid/out_ready downstream handshake
//   alu_op              ALU control code (*_CONTROL encoding)
//   alu_src_imm         1: operand B = imm_ext, 0: operand B = rt register
//   imm_ext             sign- or zero-extended immediate
//   rs, rt, rd          register fields, rd is the write-back destination
//   reg_write           instruction writes the register file
//   illegal             held instruction is unsupported
//   ill_count           saturating count of accepted illegal instructions
module alu_ctrl_decode_stage #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           alu_op,
  output logic                 alu_src_imm,
  output logic [31:0]          imm_ext,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  // ALU control encodings shared with the EX-stage ALU
  localparam logic [4:0] AND_CONTROL = 5'b00000;
  localparam logic [4:0] OR_CONTROL  = 5'b00001;
  localparam logic [4:0] XOR_CONTROL = 5'b00010;
  localparam logic [4:0] NOR_CONTROL = 5'b00011;
  localparam logic [4:0] ADD_CONTROL = 5'b10000;
  localparam logic [4:0] SUB_CONTROL = 5'b10010;
  localparam logic [4:0] SLT_CONTROL = 5'b10100;

  localparam logic [ILL_CNT_W-1:0] CNT_MAX = {ILL_CNT_W{1'b1}};

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  dec_op_s;
  logic        dec_src_imm_s;
  logic        dec_zext_s;
  logic [4:0]  dec_rd_s;
  logic        dec_wr_s;
  logic        dec_ill_s;
  logic [31:0] dec_imm_s;
  logic        accept_s;

  logic                 out_valid_r;
  logic [4:0]           alu_op_r;
  logic                 alu_src_imm_r;
  logic [31:0]          imm_ext_r;
  logic [4:0]           rs_r;
  logic [4:0]           rt_r;
  logic [4:0]           rd_r;
  logic                 reg_write_r;
  logic                 illegal_r;
  logic [ILL_CNT_W-1:0] ill_count_r;

  assign opcode_s = instr[31:26];
  assign funct_s  = instr[5:0];
  assign dec_imm_s = dec_zext_s ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};

  // No skid buffer: a new word is taken only when the register is empty or draining.
  assign in_ready = ~out_valid_r | out_ready;
  assign accept_s = in_valid & in_ready & ~flush;

  // Instruction decode into ALU control, operand select, destination and legality
  always_comb begin
    dec_op_s      = ADD_CONTROL;
    dec_src_imm_s = 1'b0;
    dec_zext_s    = 1'b0;
    dec_rd_s      = instr[20:16];
    dec_wr_s      = 1'b0;
    dec_ill_s     = 1'b0;
    case (opcode_s)
      6'h00: begin
        dec_rd_s = instr[15:11];
        if (instr == 32'h0000_0000) begin
          // all-zero word is the canonical nop: legal, writes nothing
          dec_wr_s = 1'b0;
        end else begin
          dec_wr_s = 1'b1;
          case (funct_s)
            6'h20, 6'h21: dec_op_s = ADD_CONTROL;
            6'h22, 6'h23: dec_op_s = SUB_CONTROL;
            6'h24:        dec_op_s = AND_CONTROL;
            6'h25:        dec_op_s = OR_CONTROL;
            6'h26:        dec_op_s = XOR_CONTROL;
            6'h27:        dec_op_s = NOR_CONTROL;
            6'h2A:        dec_op_s = SLT_CONTROL;
            default: begin
              dec_op_s  = ADD_CONTROL;
              dec_wr_s  = 1'b0;
              dec_ill_s = 1'b1;
            end
          endcase
        end
      end
      6'h08, 6'h09: begin
        dec_src_imm_s = 1'b1;
        dec_wr_s      = 1'b1;
      end
      6'h0A: begin
        dec_op_s      = SLT_CONTROL;
        dec_src_imm_s = 1'b1;
        dec_wr_s      = 1'b1;
      end
      6'h0C: begin
        dec_op_s      = AND_CONTROL;
        dec_src_imm_s = 1'b1;
        dec_zext_s    = 1'b1;
        dec_wr_s      = 1'b1;
      end
      6'h0D: begin
        dec_op_s      = OR_CONTROL;
        dec_src_imm_s = 1'b1;
        dec_zext_s    = 1'b1;
        dec_wr_s      = 1'b1;
      end
      6'h0E: begin
        dec_op_s      = XOR_CONTROL;
        dec_src_imm_s = 1'b1;
        dec_zext_s    = 1'b1;
        dec_wr_s      = 1'b1;
      end
      6'h23: begin
        dec_src_imm_s = 1'b1;
        dec_wr_s      = 1'b1;
      end
      6'h2B: begin
        dec_src_imm_s = 1'b1;
      end
      6'h04, 6'h05: begin
        // branches compare rs against rt
        dec_op_s = SUB_CONTROL;
      end
      default: begin
        dec_ill_s = 1'b1;
      end
    endcase
  end

  // ID/EX register: reset, flush, accept, drain or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      alu_op_r      <= ADD_CONTROL;
      alu_src_imm_r <= 1'b0;
      imm_ext_r     <= 32'h0000_0000;
      rs_r          <= 5'd0;
      rt_r          <= 5'd0;
      rd_r          <= 5'd0;
      reg_write_r   <= 1'b0;
      illegal_r     <= 1'b0;
      ill_count_r   <= {ILL_CNT_W{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r   <= 1'b1;
      alu_op_r      <= dec_op_s;
      alu_src_imm_r <= dec_src_imm_s;
      imm_ext_r     <= dec_imm_s;
      rs_r          <= instr[25:21];
      rt_r          <= instr[20:16];
      rd_r          <= dec_rd_s;
      reg_write_r   <= dec_wr_s;
      illegal_r     <= dec_ill_s;
      if (dec_ill_s && (ill_count_r != CNT_MAX)) begin
        ill_count_r <= ill_count_r + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        ill_count_r <= ill_count_r;
      end
    end else if (out_ready) begin
      // drained: data fields keep their last value
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid   = out_valid_r;
  assign alu_op      = alu_op_r;
  assign alu_src_imm = alu_src_imm_r;
  assign imm_ext     = imm_ext_r;
  assign rs          = rs_r;
  assign rt          = rt_r;
  assign rd          = rd_r;
  assign reg_write   = reg_write_r;
  assign illegal     = illegal_r;
  assign ill_count   = ill_count_r;

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
module tb_alu_ctrl_decode_stage;

  localparam logic [4:0] C_AND = 5'b00000;
  localparam logic [4:0] C_OR  = 5'b00001;
  localparam logic [4:0] C_XOR = 5'b00010;
  localparam logic [4:0] C_NOR = 5'b00011;
  localparam logic [4:0] C_ADD = 5'b10000;
  localparam logic [4:0] C_SUB = 5'b10010;
  localparam logic [4:0] C_SLT = 5'b10100;

  typedef struct packed {
    logic [4:0]  op;
    logic        src;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  alu_op;
  logic        alu_src_imm;
  logic [31:0] imm_ext;
  logic [4:0]  rs, rt, rd;
  logic        reg_write;
  logic        illegal;
  logic [7:0]  ill_count;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  alu_ctrl_decode_stage #(.ILL_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .imm_ext(imm_ext), .rs(rs), .rt(rt), .rd(rd),
    .reg_write(reg_write), .illegal(illegal), .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
  endtask

  // Reference decode straight from the instruction-set table
  function automatic exp_t decode(input logic [31:0] w);
    exp_t e;
    logic [5:0] opc = w[31:26];
    logic [5:0] fn = w[5:0];
    e.op = C_ADD; e.src = 1'b0; e.imm = {{16{w[15]}}, w[15:0]};
    e.rs = w[25:21]; e.rt = w[20:16]; e.rd = w[20:16]; e.wr = 1'b0; e.ill = 1'b0;
    if (w == 32'h0) return e;
    if (opc == 6'h00) begin
      e.rd = w[15:11]; e.wr = 1'b1;
      if (fn == 6'h20 || fn == 6'h21) e.op = C_ADD;
      else if (fn == 6'h22 || fn == 6'h23) e.op = C_SUB;
      else if (fn == 6'h24) e.op = C_AND;
      else if (fn == 6'h25) e.op = C_OR;
      else if (fn == 6'h26) e.op = C_XOR;
      else if (fn == 6'h27) e.op = C_NOR;
      else if (fn == 6'h2A) e.op = C_SLT;
      else begin e.wr = 1'b0; e.ill = 1'b1; end
      return e;
    end
    if (opc == 6'h08 || opc == 6'h09 || opc == 6'h23) begin e.src = 1'b1; e.wr = 1'b1; end
    else if (opc == 6'h0A) begin e.op = C_SLT; e.src = 1'b1; e.wr = 1'b1; end
    else if (opc >= 6'h0C && opc <= 6'h0E) begin
      e.op = (opc == 6'h0C) ? C_AND : (opc == 6'h0D) ? C_OR : C_XOR;
      e.src = 1'b1; e.wr = 1'b1; e.imm = {16'h0000, w[15:0]};
    end
    else if (opc == 6'h2B) e.src = 1'b1;
    else if (opc == 6'h04 || opc == 6'h05) e.op = C_SUB;
    else e.ill = 1'b1;
    return e;
  endfunction

  // Transaction-level model of the ID/EX register
  exp_t m_e;
  bit   m_valid;
  int   m_cnt;
  bit   m_chk_rd, m_chk_imm;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_e <= '{op: C_ADD, src: 1'b0, imm: 32'h0, rs: 5'd0, rt: 5'd0, rd: 5'd0, wr: 1'b0, ill: 1'b0};
      m_cnt <= 0; m_chk_rd <= 1'b1; m_chk_imm <= 1'b1;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_e <= decode(instr);
      m_chk_rd <= decode(instr).wr;
      m_chk_imm <= decode(instr).src;
      if (decode(instr).ill && m_cnt < 255) m_cnt <= m_cnt + 1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison of DUT against the model
  always @(negedge clk) begin
    if (started) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid) | out_ready});
      check("alu_op", {27'd0, alu_op}, {27'd0, m_e.op});
      check("alu_src_imm", {31'd0, alu_src_imm}, {31'd0, m_e.src});
      check("reg_write", {31'd0, reg_write}, {31'd0, m_e.wr});
      check("illegal", {31'd0, illegal}, {31'd0, m_e.ill});
      check("ill_count", {24'd0, ill_count}, m_cnt);
      check("rs", {27'd0, rs}, {27'd0, m_e.rs});
      check("rt", {27'd0, rt}, {27'd0, m_e.rt});
      if (m_chk_rd) check("rd", {27'd0, rd}, {27'd0, m_e.rd});
      if (m_chk_imm) check("imm_ext", imm_ext, m_e.imm);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] i, input logic ordy, input logic fl);
    in_valid = v; instr = i; out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  logic [31:0] vec [0:11];

  initial begin
    // reset two cycles
    rst = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    started = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_imm", imm_ext, 32'h0);
    rst = 1'b0;

    // add $8,$9,$10
    cyc(1'b1, 32'h012A4020, 1'b1, 1'b0);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_op", {27'd0, alu_op}, {27'd0, C_ADD});
    check("t1_rd", {27'd0, rd}, 32'd8);
    check("t1_rs", {27'd0, rs}, 32'd9);
    check("t1_rt", {27'd0, rt}, 32'd10);
    check("t1_wr", {31'd0, reg_write}, 32'd1);
    check("t1_src", {31'd0, alu_src_imm}, 32'd0);

    // andi then addi back to back
    cyc(1'b1, 32'h3128FFFF, 1'b1, 1'b0);
    check("t2_andi_imm", imm_ext, 32'h0000FFFF);
    check("t2_andi_op", {27'd0, alu_op}, {27'd0, C_AND});
    check("t2_andi_rd", {27'd0, rd}, 32'd8);
    cyc(1'b1, 32'h2128FFFF, 1'b1, 1'b0);
    check("t2_addi_imm", imm_ext, 32'hFFFFFFFF);
    check("t2_addi_op", {27'd0, alu_op}, {27'd0, C_ADD});
    check("t2_addi_rd", {27'd0, rd}, 32'd8);

    // sub, then back-pressure for 3 cycles, then release
    cyc(1'b1, 32'h012A4022, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 32'h012A4025, 1'b0, 1'b0);
      check("t3_in_ready", {31'd0, in_ready}, 32'd0);
      check("t3_hold_op", {27'd0, alu_op}, {27'd0, C_SUB});
    end
    cyc(1'b1, 32'h012A4025, 1'b1, 1'b0);
    check("t3_next_op", {27'd0, alu_op}, {27'd0, C_OR});

    // flush beats accept; illegal flushed word does not count
    cyc(1'b1, 32'hFC000000, 1'b1, 1'b1);
    check("t4_valid", {31'd0, out_valid}, 32'd0);
    check("t4_op_kept", {27'd0, alu_op}, {27'd0, C_OR});
    check("t4_cnt", {24'd0, ill_count}, 32'd0);

    // table of assorted encodings, including drain gaps
    vec[0] = 32'h00000000; vec[1] = 32'h012A4027; vec[2] = 32'h012A402A; vec[3] = 32'h2928FF00;
    vec[4] = 32'h3928F0F0; vec[5] = 32'h3528800F; vec[6] = 32'h8D28FFFC; vec[7] = 32'hAD280004;
    vec[8] = 32'h112AFFFE; vec[9] = 32'h152A0003; vec[10] = 32'h012A4026; vec[11] = 32'h00094080;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, vec[k], 1'b1, 1'b0);
      if (k % 3 == 2) cyc(1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    end
    cyc(1'b1, 32'h00000000, 1'b1, 1'b0);
    check("nop_ill", {31'd0, illegal}, 32'd0);
    check("nop_wr", {31'd0, reg_write}, 32'd0);

    // illegal stream saturates counter (sll above counted once)
    for (int k = 0; k < 260; k++) cyc(1'b1, 32'hFC000000, 1'b1, 1'b0);
    check("t5_cnt", {24'd0, ill_count}, 32'd255);
    check("t5_ill", {31'd0, illegal}, 32'd1);
    check("t5_wr", {31'd0, reg_write}, 32'd0);

    // reset while holding
    cyc(1'b1, 32'h2128FFFF, 1'b1, 1'b0);
    cyc(1'b1, 32'h012A4020, 1'b0, 1'b0);
    check("t6_held", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    cyc(1'b1, 32'h012A4020, 1'b0, 1'b1);
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    check("t6_cnt", {24'd0, ill_count}, 32'd0);
    check("t6_imm", imm_ext, 32'h0);
    check("t6_rd", {27'd0, rd}, 32'd0);
    check("t6_op", {27'd0, alu_op}, {27'd0, C_ADD});
    rst = 1'b0;
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
